// File: rtl/conv_win_pkg.sv
// Shared constants, state encoding and tap-offset helper for the 3x3 window generator.
// Optional build macro: CONV_WIN_STRIDE2_EN selects a column step of 2 instead of 1.
package conv_win_pkg;

    localparam int PIX_W   = 8;
    localparam int ROW_PIX = 418;
    localparam int ROW_W   = ROW_PIX * PIX_W;
    localparam int NCOL    = ROW_PIX - 2;
    localparam int WIN_W   = 9 * PIX_W;

`ifdef CONV_WIN_STRIDE2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    // Highest column reachable from 0 in whole steps: 415 at stride 1, 414 at stride 2.
    localparam int LAST_COL = ((NCOL - 1) / STEP) * STEP;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // MSB position of tap (r,k) inside a packed 3x3 window; tap (0,0) sits in the top byte.
    function automatic int tap_msb(input int r, input int k);
        return WIN_W - 1 - PIX_W * (3 * r + k);
    endfunction

endpackage

// File: rtl/row_shift_reg.sv
// One padded-row register: parallel load of a whole row, left shift by STEP pixels with
// zero fill, and the three leading pixels exposed as the window taps for this row.
module row_shift_reg
    import conv_win_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [ROW_W-1:0]     row_i,
    output logic [3*PIX_W-1:0]   taps_o
);

    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;

    // Load wins over shift; otherwise hold the row.
    always_comb begin
        row_d = row_q;
        if (load_i) begin
            row_d = row_i;
        end else if (shift_i) begin
            row_d = {row_q[ROW_W-1-STEP*PIX_W:0], {(STEP*PIX_W){1'b0}}};
        end
    end

    // Row storage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign taps_o = row_q[ROW_W-1 -: 3*PIX_W];

endmodule

// File: rtl/conv_window_gen.sv
// Sliding 3x3x3 window generator: captures a band of three padded rows per channel and
// streams one window per accepted cycle. Build macro CONV_WIN_STRIDE2_EN selects stride 2.
//
//   state  | meaning
//   IDLE   | load_ready high, waiting for row_load to capture a band
//   STREAM | win_valid high, presenting the window at win_col until the last is accepted
module conv_window_gen
    import conv_win_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               row_load,
    output logic               load_ready,
    input  logic [ROW_W-1:0]   R_row0,
    input  logic [ROW_W-1:0]   G_row0,
    input  logic [ROW_W-1:0]   B_row0,
    input  logic [ROW_W-1:0]   R_row1,
    input  logic [ROW_W-1:0]   G_row1,
    input  logic [ROW_W-1:0]   B_row1,
    input  logic [ROW_W-1:0]   R_row2,
    input  logic [ROW_W-1:0]   G_row2,
    input  logic [ROW_W-1:0]   B_row2,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [WIN_W-1:0]   R_win,
    output logic [WIN_W-1:0]   G_win,
    output logic [WIN_W-1:0]   B_win,
    output logic [8:0]         win_col,
    output logic               win_last
);

    localparam logic [8:0] LAST_COL_V = 9'(LAST_COL);
    localparam logic [8:0] COL_STEP   = 9'(STEP);

    state_t     state_q, state_d;
    logic [8:0] col_q, col_d;
    logic       last_w;
    logic       load_w;
    logic       shift_w;

    logic [ROW_W-1:0]   rows [3][3];
    logic [3*PIX_W-1:0] taps [3][3];

    assign rows[0][0] = R_row0;
    assign rows[0][1] = R_row1;
    assign rows[0][2] = R_row2;
    assign rows[1][0] = G_row0;
    assign rows[1][1] = G_row1;
    assign rows[1][2] = G_row2;
    assign rows[2][0] = B_row0;
    assign rows[2][1] = B_row1;
    assign rows[2][2] = B_row2;

    assign last_w  = (state_q == STREAM) && (col_q == LAST_COL_V);
    assign load_w  = (state_q == IDLE) && row_load;
    assign shift_w = (state_q == STREAM) && win_ready && !last_w;

    // Channel-major instance grid: index 0/1/2 = R/G/B, then row 0..2.
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        for (genvar r = 0; r < 3; r++) begin : g_row
            row_shift_reg u_row (
                .clk     (clk),
                .reset   (reset),
                .load_i  (load_w),
                .shift_i (shift_w),
                .row_i   (rows[ch][r]),
                .taps_o  (taps[ch][r])
            );
        end
    end

    // Next state and column; row_load outside IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (row_load) begin
                    state_d = STREAM;
                    col_d   = '0;
                end
            end
            STREAM: begin
                if (win_ready) begin
                    if (last_w) begin
                        state_d = IDLE;
                    end else begin
                        col_d = col_q + COL_STEP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and column counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // Pack each row's three taps into the window bus for its channel.
    always_comb begin
        R_win = '0;
        G_win = '0;
        B_win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                R_win[tap_msb(r, k) -: PIX_W] = taps[0][r][3*PIX_W-1-PIX_W*k -: PIX_W];
                G_win[tap_msb(r, k) -: PIX_W] = taps[1][r][3*PIX_W-1-PIX_W*k -: PIX_W];
                B_win[tap_msb(r, k) -: PIX_W] = taps[2][r][3*PIX_W-1-PIX_W*k -: PIX_W];
            end
        end
    end

    assign load_ready = (state_q == IDLE);
    assign win_valid  = (state_q == STREAM);
    assign win_col    = col_q;
    assign win_last   = last_w;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: bands are loaded with directed pixel patterns,
// the expected windows are queued at load time and a negedge monitor checks each accepted
// window, stall stability and the return to idle.
module tb_conv_window_gen;
    import conv_win_pkg::*;

    localparam int NW = LAST_COL / STEP + 1;

    typedef struct {
        logic [WIN_W-1:0] r;
        logic [WIN_W-1:0] g;
        logic [WIN_W-1:0] b;
        logic [8:0]       col;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic reset, row_load, win_ready;
    logic load_ready, win_valid, win_last;
    logic [ROW_W-1:0] R_row0, G_row0, B_row0, R_row1, G_row1, B_row1, R_row2, G_row2, B_row2;
    logic [WIN_W-1:0] R_win, G_win, B_win;
    logic [8:0] win_col;

    int errors = 0;
    int checks = 0;
    exp_t q[$];
    bit exp_idle = 0;
    bit stalled = 0;
    logic [WIN_W-1:0] s_r, s_g, s_b;
    logic [8:0] s_col;
    logic s_last;

    always #5 clk = ~clk;

    conv_window_gen dut (
        .clk(clk), .reset(reset), .row_load(row_load), .load_ready(load_ready),
        .R_row0(R_row0), .G_row0(G_row0), .B_row0(B_row0),
        .R_row1(R_row1), .G_row1(G_row1), .B_row1(B_row1),
        .R_row2(R_row2), .G_row2(G_row2), .B_row2(B_row2),
        .win_valid(win_valid), .win_ready(win_ready),
        .R_win(R_win), .G_win(G_win), .B_win(B_win),
        .win_col(win_col), .win_last(win_last)
    );

    function automatic logic [7:0] pix(input int ch, input int r, input int i, input int off);
        logic [7:0] rv;
        rv = 8'((i + 64 * r + off) & 255);
        case (ch)
            0:       return rv;
            1:       return rv ^ 8'hFF;
            default: return rv + 8'd1;
        endcase
    endfunction

    function automatic logic [WIN_W-1:0] exp_win(input int ch, input int c, input int off);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                w[WIN_W-1-8*(3*r+k) -: 8] = pix(ch, r, c + k, off);
        return w;
    endfunction

    task automatic set_rows(input int off);
        for (int i = 0; i < ROW_PIX; i++) begin
            R_row0[ROW_W-1-8*i -: 8] = pix(0, 0, i, off);
            R_row1[ROW_W-1-8*i -: 8] = pix(0, 1, i, off);
            R_row2[ROW_W-1-8*i -: 8] = pix(0, 2, i, off);
            G_row0[ROW_W-1-8*i -: 8] = pix(1, 0, i, off);
            G_row1[ROW_W-1-8*i -: 8] = pix(1, 1, i, off);
            G_row2[ROW_W-1-8*i -: 8] = pix(1, 2, i, off);
            B_row0[ROW_W-1-8*i -: 8] = pix(2, 0, i, off);
            B_row1[ROW_W-1-8*i -: 8] = pix(2, 1, i, off);
            B_row2[ROW_W-1-8*i -: 8] = pix(2, 2, i, off);
        end
    endtask

    task automatic push_band(input int off);
        exp_t e;
        for (int c = 0; c <= LAST_COL; c += STEP) begin
            e.r = exp_win(0, c, off);
            e.g = exp_win(1, c, off);
            e.b = exp_win(2, c, off);
            e.col = 9'(c);
            e.last = (c == LAST_COL);
            q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Loads a band (caller guarantees load_ready) and drives win_ready until the DUT is idle again.
    task automatic run_band(input int off, input bit rnd, input bit pulse);
        int cyc;
        bit pulsed;
        bit first;
        set_rows(off);
        row_load = 1'b1;
        @(posedge clk); #1;
        row_load = 1'b0;
        push_band(off);
        cyc = 0;
        pulsed = 0;
        first = 1;
        while (!load_ready && cyc < 5000) begin
            win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse && !pulsed && win_col == 9'd100) begin
                set_rows(off ^ 8'h5A);
                row_load = 1'b1;
                pulsed = 1;
            end
            @(negedge clk);
            if (first) begin
                check("load_latency_valid", WIN_W'(win_valid), WIN_W'(1));
                first = 0;
            end
            @(posedge clk); #1;
            row_load = 1'b0;
            cyc++;
        end
        if (!load_ready) begin
            errors++;
            $display("FAIL band_timeout: load_ready %0b after %0d cycles, expected 1", load_ready, cyc);
        end
    endtask

    // Monitor: compare accepted windows, stall stability and idle after the last window.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 0;
            exp_idle = 0;
        end else begin
            if (exp_idle) begin
                check("idle_after_last", WIN_W'({win_valid, load_ready}), WIN_W'(2'b01));
                exp_idle = 0;
            end
            if (win_valid && stalled) begin
                check("stall_stable", {R_win ^ s_r, G_win ^ s_g, B_win ^ s_b, win_col ^ s_col, win_last ^ s_last}, '0);
            end
            if (win_valid && win_ready) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_window: col %0d with empty scoreboard", win_col);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("win_col", WIN_W'(win_col), WIN_W'(e.col));
                    check("win_last", WIN_W'(win_last), WIN_W'(e.last));
                    check("R_win", R_win, e.r);
                    check("G_win", G_win, e.g);
                    check("B_win", B_win, e.b);
                    if (e.last) exp_idle = 1;
                end
            end
            stalled = win_valid && !win_ready;
            s_r = R_win; s_g = G_win; s_b = B_win; s_col = win_col; s_last = win_last;
        end
    end

    initial begin
        reset = 1'b1;
        row_load = 1'b0;
        win_ready = 1'b0;
        set_rows(0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_load_ready", WIN_W'(load_ready), WIN_W'(1));
        check("rst_win_valid", WIN_W'(win_valid), WIN_W'(0));
        check("rst_windows", R_win | G_win | B_win, '0);
        @(posedge clk); #1;

        // Reset in the middle of a band.
        set_rows(0);
        row_load = 1'b1;
        win_ready = 1'b1;
        @(posedge clk); #1;
        row_load = 1'b0;
        push_band(0);
        repeat (20) @(posedge clk);
        #1 win_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        @(negedge clk);
        check("midrst_win_valid", WIN_W'(win_valid), WIN_W'(0));
        check("midrst_win_col", WIN_W'(win_col), WIN_W'(0));
        check("midrst_win_last", WIN_W'(win_last), WIN_W'(0));
        check("midrst_windows", R_win | G_win | B_win, '0);
        check("midrst_load_ready", WIN_W'(load_ready), WIN_W'(1));
        @(posedge clk); #1;

        // Basic band, then back-to-back bands under random backpressure with an ignored load.
        run_band(0, 0, 0);
        run_band(8'h80, 1, 1);
        run_band(8'h33, 1, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", WIN_W'(q.size()), WIN_W'(0));
        check("final_idle", WIN_W'({win_valid, load_ready}), WIN_W'(2'b01));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
